execute_muldiv: RTL

Parametrised next-generation execute stage for the MIPS datapath. Operand select, ALU control decode, ALU and shifter are folded into one block, and the output is registered. It adds an iterative multiply/divide unit with HI/LO registers. A valid/ready handshake lets decode stall while a multi-cycle mult/div is in progress.

---
 rtl/execute_muldiv.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_muldiv.sv
// Execute stage: operand select, ALU decode, ALU/shifter and an iterative mult/div unit with HI/LO.
// Latency: single-cycle ops give out_valid in the next cycle; mult/div give out_valid WIDTH+1 cycles after accept.
// Backpressure: in_ready drops from the cycle after a mult/div accept through its DONE cycle, which stalls decode.
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-high reset
//   in_valid / in_ready       decode handshake; accept = in_valid && in_ready
//   read_data1, read_data2    rs / rt operands
//   immediate                 extended immediate; bits [10:6] carry shamt
//   funct, alu_op, alu_src    R-type function field, operation class, operand-B select
//   out_valid                 one-cycle pulse qualifying alu_result / zero
//   alu_result, zero          registered result and its zero flag
//   hi, lo                    HI / LO registers
//   busy                      mult/div in progress
module execute_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] immediate,
    input  logic [5:0]       funct,
    input  logic [2:0]       alu_op,
    input  logic             alu_src,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_alu_result;
    logic               r_zero;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Iteration registers: r_acc is the running upper half (product) or
    // partial remainder (divide); r_mlo holds the multiplier / quotient bits.
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mlo;
    logic [WIDTH-1:0]   r_opb;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_dividend;

    logic               w_accept;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_slt;
    logic [WIDTH-1:0]   w_sltu;
    logic [WIDTH-1:0]   w_imm_sh;
    logic               w_unused_imm;
    logic [SHAMT_W-1:0] w_shamt_i;
    logic [SHAMT_W-1:0] w_shamt_v;
    logic [WIDTH-1:0]   w_alu;
    logic               w_is_mthi;
    logic               w_is_mtlo;
    logic               w_md_start;
    logic               w_md_div;
    logic               w_md_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = r_out_valid;
    assign alu_result = r_alu_result;
    assign zero       = r_zero;
    assign hi         = r_hi;
    assign lo         = r_lo;

    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    assign w_opb  = alu_src ? read_data2 : immediate;
    assign w_sum  = read_data1 + w_opb;
    assign w_diff = read_data1 - w_opb;
    assign w_slt  = {{(WIDTH-1){1'b0}}, ($signed(read_data1) < $signed(w_opb))};
    assign w_sltu = {{(WIDTH-1){1'b0}}, (read_data1 < w_opb)};

    // shamt sits at immediate[10:6]; only the low SHAMT_W bits are meaningful.
    assign w_imm_sh     = immediate >> 6;
    assign w_shamt_i    = w_imm_sh[SHAMT_W-1:0];
    assign w_unused_imm = ^w_imm_sh[WIDTH-1:SHAMT_W];
    assign w_shamt_v    = read_data1[SHAMT_W-1:0];

    always_comb begin
        w_alu       = '0;
        w_is_mthi   = 1'b0;
        w_is_mtlo   = 1'b0;
        w_md_start  = 1'b0;
        w_md_div    = 1'b0;
        w_md_signed = 1'b0;
        case (alu_op)
            3'b000, 3'b111: w_alu = w_sum;
            3'b001:         w_alu = w_diff;
            3'b011:         w_alu = read_data1 & w_opb;
            3'b100:         w_alu = read_data1 | w_opb;
            3'b101:         w_alu = w_slt;
            3'b110:         w_alu = w_opb << (WIDTH / 2);
            3'b010: begin
                case (funct)
                    6'h20, 6'h21: w_alu = w_sum;
                    6'h22, 6'h23: w_alu = w_diff;
                    6'h24:        w_alu = read_data1 & w_opb;
                    6'h25:        w_alu = read_data1 | w_opb;
                    6'h26:        w_alu = read_data1 ^ w_opb;
                    6'h27:        w_alu = ~(read_data1 | w_opb);
                    6'h2A:        w_alu = w_slt;
                    6'h2B:        w_alu = w_sltu;
                    6'h00:        w_alu = read_data2 << w_shamt_i;
                    6'h02:        w_alu = read_data2 >> w_shamt_i;
                    6'h03:        w_alu = $signed(read_data2) >>> w_shamt_i;
                    6'h04:        w_alu = read_data2 << w_shamt_v;
                    6'h06:        w_alu = read_data2 >> w_shamt_v;
                    6'h07:        w_alu = $signed(read_data2) >>> w_shamt_v;
                    6'h10:        w_alu = r_hi;
                    6'h12:        w_alu = r_lo;
                    6'h11: begin
                        w_alu     = read_data1;
                        w_is_mthi = 1'b1;
                    end
                    6'h13: begin
                        w_alu     = read_data1;
                        w_is_mtlo = 1'b1;
                    end
                    6'h18: begin
                        w_md_start  = 1'b1;
                        w_md_signed = 1'b1;
                    end
                    6'h19: w_md_start = 1'b1;
                    6'h1A: begin
                        w_md_start  = 1'b1;
                        w_md_div    = 1'b1;
                        w_md_signed = 1'b1;
                    end
                    6'h1B: begin
                        w_md_start = 1'b1;
                        w_md_div   = 1'b1;
                    end
                    default: w_alu = '0;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    // Signed variants iterate on magnitudes; the sign is restored at the end.
    assign w_mag_a = (w_md_signed && read_data1[WIDTH-1]) ? -read_data1 : read_data1;
    assign w_mag_b = (w_md_signed && read_data2[WIDTH-1]) ? -read_data2 : read_data2;

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [WIDTH-1:0]   w_div_acc;
    logic [WIDTH-1:0]   w_div_lo;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    // Add the multiplicand into the upper half when the current multiplier
    // bit is set, then shift the whole {carry, upper, lower} right by one.
    assign w_mul_sum = {1'b0, r_acc} + {1'b0, (r_mlo[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_acc = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_mlo[WIDTH-1:1]};

    // Shift the next dividend bit into the partial remainder and subtract the
    // divisor if it fits. The remainder is always below the divisor, so the
    // subtraction result fits in WIDTH bits.
    assign w_div_sh  = {r_acc, r_mlo[WIDTH-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_opb});
    assign w_div_sub = w_div_sh[WIDTH-1:0] - r_opb;
    assign w_div_acc = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
    assign w_div_lo  = {r_mlo[WIDTH-2:0], w_div_ge};

    assign w_step_acc = (r_state == S_DIV) ? w_div_acc : w_mul_acc;
    assign w_step_lo  = (r_state == S_DIV) ? w_div_lo  : w_mul_lo;

    assign w_prod     = {w_mul_acc, w_mul_lo};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

    // Final HI/LO, computed from the last iteration's next-state values so
    // they can be registered on the same edge that enters DONE.
    always_comb begin
        w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_lo = w_prod_fix[WIDTH-1:0];
        if (r_state == S_DIV) begin
            if (r_div0) begin
                w_fin_hi = r_dividend;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = r_neg_rem ? -w_div_acc : w_div_acc;
                w_fin_lo = r_neg_res ? -w_div_lo  : w_div_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_alu_result <= '0;
            r_zero       <= 1'b1;
            r_out_valid  <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_acc        <= '0;
            r_mlo        <= '0;
            r_opb        <= '0;
            r_cnt        <= '0;
            r_neg_res    <= 1'b0;
            r_neg_rem    <= 1'b0;
            r_div0       <= 1'b0;
            r_dividend   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_md_start) begin
                            r_state    <= w_md_div ? S_DIV : S_MUL;
                            r_acc      <= '0;
                            r_mlo      <= w_mag_a;
                            r_opb      <= w_mag_b;
                            r_cnt      <= '0;
                            r_neg_res  <= w_md_signed & (read_data1[WIDTH-1] ^ read_data2[WIDTH-1]);
                            r_neg_rem  <= w_md_signed & read_data1[WIDTH-1];
                            r_div0     <= (read_data2 == '0);
                            r_dividend <= read_data1;
                        end else begin
                            r_alu_result <= w_alu;
                            r_zero       <= (w_alu == '0);
                            r_out_valid  <= 1'b1;
                            if (w_is_mthi) r_hi <= read_data1;
                            if (w_is_mtlo) r_lo <= read_data1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_step_acc;
                    r_mlo <= w_step_lo;
                    r_cnt <= r_cnt + 1'b1;
                    // r_cnt all ones marks the WIDTH-th iteration.
                    if (&r_cnt) begin
                        r_state      <= S_DONE;
                        r_hi         <= w_fin_hi;
                        r_lo         <= w_fin_lo;
                        r_alu_result <= w_fin_lo;
                        r_zero       <= (w_fin_lo == '0);
                        r_out_valid  <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
